// File: rtl/imem_loader.sv
// Boot loader: receives a framed big-endian byte stream, writes 32-bit words into
// instruction memory from address 0 and holds the CPU in reset until the image checks out.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // 17 bits so that a full 16-bit count can be compared against the capacity exactly.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_in_ready;
  logic [15:0]           r_count;
  logic [15:0]           r_word_idx;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_asm;
  logic [7:0]            r_csum;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic [15:0]           w_n_hdr;
  logic                  w_oversize;
  logic                  w_last_word;
  logic                  w_next_loading;

  assign w_accept       = in_valid && r_in_ready;
  assign w_n_hdr        = {r_count[15:8], in_data};
  assign w_oversize     = {1'b0, w_n_hdr} > CAPACITY;
  assign w_last_word    = (r_word_idx + 16'd1) == r_count;
  assign w_next_loading = (w_next_state != S_DONE) && (w_next_state != S_ERR);

  assign in_ready   = r_in_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign err        = r_err;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode from the current state and the accepted byte.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HDR0: begin
        if (w_accept) w_next_state = S_HDR1;
        else          w_next_state = r_state;
      end
      S_HDR1: begin
        if (!w_accept)               w_next_state = r_state;
        else if (w_oversize)         w_next_state = S_ERR;
        else if (w_n_hdr == 16'd0)   w_next_state = S_CSUM;
        else                         w_next_state = S_DATA;
      end
      S_DATA: begin
        if (w_accept && (r_byte_idx == 2'd3) && w_last_word) w_next_state = S_CSUM;
        else                                                 w_next_state = r_state;
      end
      S_CSUM: begin
        if (!w_accept)             w_next_state = r_state;
        else if (in_data == r_csum) w_next_state = S_DONE;
        else                        w_next_state = S_ERR;
      end
      S_DONE, S_ERR: begin
        if (restart) w_next_state = S_HDR0;
        else         w_next_state = r_state;
      end
      default: w_next_state = S_HDR0;
    endcase
  end

  // Datapath: header capture, word assembly, checksum and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_count     <= 16'd0;
      r_word_idx  <= 16'd0;
      r_byte_idx  <= 2'd0;
      r_asm       <= 24'd0;
      r_csum      <= 8'h00;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_in_ready <= w_next_loading;
      r_we       <= 1'b0;
      case (r_state)
        S_HDR0: begin
          if (w_accept) r_count[15:8] <= in_data;
        end
        S_HDR1: begin
          if (w_accept) begin
            r_count[7:0] <= in_data;
            r_err        <= w_oversize;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum     <= csum_update(r_csum, in_data);
            r_byte_idx <= r_byte_idx + 2'd1;
            r_asm      <= {r_asm[15:0], in_data};
            if (r_byte_idx == 2'd3) begin
              r_we       <= 1'b1;
              r_wdata    <= {r_asm, in_data};
              r_addr     <= r_word_idx[ADDR_WIDTH-1:0];
              r_word_idx <= r_word_idx + 16'd1;
            end
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            if (in_data == r_csum) begin
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          // Leaving a terminal state starts a fresh frame with the CPU held again.
          if (restart) begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_csum      <= 8'h00;
            r_byte_idx  <= 2'd0;
            r_word_idx  <= 16'd0;
            r_count     <= 16'd0;
          end
        end
        default: begin
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a byte-count-driven frame model predicts every output each
// cycle, and directed frames are additionally pinned with hand-computed literals.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          restart = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame model: everything follows from how many bytes of the current frame were taken.
  int            m_k, m_n, m_status;   // status 0 loading, 1 done, 2 error
  logic [7:0]    m_x;
  logic [31:0]   m_word;
  logic          e_we, e_ready, e_cpu_reset, e_done, e_err;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            wc_q[$];
  logic [7:0]    frame[$];
  logic [31:0]   wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_n = 0; m_status = 0; m_x = 8'h00; m_word = 32'd0;
    e_we = 1'b0; e_addr = '0; e_wdata = 32'd0; e_ready = 1'b1;
    e_cpu_reset = 1'b1; e_done = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step();
    logic acc;
    int p;
    acc  = in_valid && e_ready;
    e_we = 1'b0;
    if (m_status != 0) begin
      if (restart) begin
        m_status = 0; m_k = 0; m_x = 8'h00;
        e_done = 1'b0; e_err = 1'b0; e_cpu_reset = 1'b1;
      end
    end else if (acc) begin
      if (m_k == 0) begin
        m_n = int'(in_data) * 256;
      end else if (m_k == 1) begin
        m_n = m_n + int'(in_data);
        if (m_n > (1 << AW)) begin m_status = 2; e_err = 1'b1; end
      end else if (m_k < 2 + 4 * m_n) begin
        p = m_k - 2;
        m_word = {m_word[23:0], in_data};
        m_x = m_x ^ in_data;
        if (p % 4 == 3) begin
          e_we = 1'b1; e_addr = AW'(p / 4); e_wdata = m_word;
        end
      end else begin
        if (in_data == m_x) begin m_status = 1; e_done = 1'b1; e_cpu_reset = 1'b0; end
        else begin m_status = 2; e_err = 1'b1; end
      end
      m_k++;
    end
    e_ready = (m_status == 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("imem_we", 32'(imem_we), 32'(e_we));
      chk("cpu_reset", 32'(cpu_reset), 32'(e_cpu_reset));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      if (e_we) begin
        chk("imem_addr", 32'(imem_addr), 32'(e_addr));
        chk("imem_wdata", imem_wdata, e_wdata);
      end
      if (imem_we === 1'b1) begin
        wa_q.push_back(imem_addr); wd_q.push_back(imem_wdata); wc_q.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic v);
    in_data = d; in_valid = v;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0);
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          restart = 1'($urandom_range(0, 1));
          drive(8'($urandom), 1'b0);
        end
        restart = 1'b0;
      end
      drive(frame[i], 1'b1);
    end
    drive(8'h00, 1'b0);
  endtask

  task automatic build(input int n);
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    foreach (wq[i]) begin
      frame.push_back(wq[i][31:24]); frame.push_back(wq[i][23:16]);
      frame.push_back(wq[i][15:8]);  frame.push_back(wq[i][7:0]);
    end
  endtask

  function automatic logic [7:0] wq_xor();
    logic [7:0] x;
    x = 8'h00;
    foreach (wq[i]) x = x ^ wq[i][31:24] ^ wq[i][23:16] ^ wq[i][15:8] ^ wq[i][7:0];
    return x;
  endfunction

  task automatic clear_writes();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    drive(8'h00, 1'b0);
    restart = 1'b0;
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_two_words(input string tag);
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      chk({tag, "_a0"}, 32'(wa_q[0]), 32'd0);
      chk({tag, "_d0"}, wd_q[0], 32'h20080005);
      chk({tag, "_a1"}, 32'(wa_q[1]), 32'd1);
      chk({tag, "_d1"}, wd_q[1], 32'hAC090004);
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    reset = 1'b0;
    idle(1);

    // N=2 good frame, back-to-back
    clear_writes();
    wq = '{32'h20080005, 32'hAC090004};
    build(2); frame.push_back(8'h8C);
    send_frame(1'b0);
    idle(2);
    check_two_words("good");
    if (wc_q.size() == 2) chk("good_spacing", 32'(wc_q[1] - wc_q[0]), 32'd4);
    chk("good_done", 32'(done), 32'd1);
    chk("good_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("good_err", 32'(err), 32'd0);

    // Bad checksum
    pulse_restart();
    clear_writes();
    build(2); frame.push_back(8'h8D);
    send_frame(1'b0);
    idle(2);
    check_two_words("bad");
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("bad_ready", 32'(in_ready), 32'd0);

    // Empty image
    pulse_restart();
    clear_writes();
    wq.delete();
    build(0); frame.push_back(8'h00);
    send_frame(1'b0);
    idle(1);
    chk("n0_nwr", 32'(wa_q.size()), 32'd0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_cpu_reset", 32'(cpu_reset), 32'd0);

    // Oversize count
    pulse_restart();
    clear_writes();
    frame = '{8'h01, 8'h01};
    send_frame(1'b0);
    idle(2);
    chk("big_nwr", 32'(wa_q.size()), 32'd0);
    chk("big_err", 32'(err), 32'd1);
    chk("big_ready", 32'(in_ready), 32'd0);

    // Full-capacity image
    pulse_restart();
    clear_writes();
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back({8'(i), ~8'(i), 8'h5A, 8'(i) ^ 8'h3C});
    build(256); frame.push_back(wq_xor());
    send_frame(1'b0);
    idle(1);
    chk("full_nwr", 32'(wa_q.size()), 32'd256);
    if (wa_q.size() == 256) begin
      chk("full_last_addr", 32'(wa_q[255]), 32'h000000FF);
      chk("full_last_data", wd_q[255], 32'hFF005AC3);
    end
    chk("full_done", 32'(done), 32'd1);

    // N=2 with random stalls and ignored restarts mid-load
    pulse_restart();
    clear_writes();
    wq = '{32'h20080005, 32'hAC090004};
    build(2); frame.push_back(8'h8C);
    send_frame(1'b1);
    idle(1);
    check_two_words("gap");
    chk("gap_done", 32'(done), 32'd1);

    // Reset mid-word, then a fresh N=1 frame
    pulse_restart();
    clear_writes();
    drive(8'h00, 1'b1); drive(8'h01, 1'b1); drive(8'h11, 1'b1); drive(8'h22, 1'b1);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    idle(2);
    reset = 1'b0;
    idle(1);
    frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_frame(1'b0);
    idle(1);
    chk("rl_nwr", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      chk("rl_addr", 32'(wa_q[0]), 32'd0);
      chk("rl_data", wd_q[0], 32'hDEADBEEF);
    end
    chk("rl_done", 32'(done), 32'd1);
    chk("rl_cpu_reset", 32'(cpu_reset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
